// File: rtl/fpu_result_writer.sv
// Result write-back stage: adder/multiplier results are captured into a small FIFO with a registered one-cycle acknowledge.
// Defining OUT_PARITY_EN adds an even-parity bit per entry, presented on out_par.
module fpu_result_writer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    input  logic                    S_req,
    input  logic                    Select,
    output logic                    S_ack,
    input  logic [DATA_W-1:0]       M1_result,
    input  logic [DATA_W-1:0]       M2_result,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_src,
`ifdef OUT_PARITY_EN
    output logic                    out_par,
`endif
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef OUT_PARITY_EN
    localparam int ENTRY_W = DATA_W + 2;
`else
    localparam int ENTRY_W = DATA_W + 1;
`endif
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_ACK,
        WB_DROP
    } wb_state_e;

    wb_state_e          state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] push_entry;
    logic [DATA_W-1:0]  push_data;
    logic               push;
    logic               pop;

    // Full check uses the registered count, so a same-cycle pop never unblocks a push.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        S_ack   = 1'b0;
        case (state_q)
            WB_IDLE: begin
                if (S_req && (count_q != FULL_COUNT)) begin
                    push    = 1'b1;
                    state_d = WB_ACK;
                end
            end
            WB_ACK: begin
                S_ack   = 1'b1;
                state_d = WB_DROP;
            end
            WB_DROP: begin
                if (!S_req) begin
                    state_d = WB_IDLE;
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    assign push_data = Select ? M2_result : M1_result;
`ifdef OUT_PARITY_EN
    assign push_entry = {^{Select, push_data}, Select, push_data};
    assign out_par    = mem_q[rd_ptr_q][DATA_W+1];
`else
    assign push_entry = {Select, push_data};
`endif

    assign out_valid  = (count_q != '0);
    assign out_data   = mem_q[rd_ptr_q][DATA_W-1:0];
    assign out_src    = mem_q[rd_ptr_q][DATA_W];
    assign fifo_count = count_q;
    assign pop        = out_valid && out_ready;

    // Pointers are exactly PTR_W bits wide, so they wrap modulo DEPTH on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q  <= WB_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left unreset; stale data is masked by out_valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

endmodule

// File: tb/tb_fpu_result_writer.sv
// Self-checking bench for fpu_result_writer: directed scenarios plus randomized traffic against a queue-based model.
// Honours OUT_PARITY_EN when defined for the build.
module tb_fpu_result_writer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              CLK = 1'b0;
    logic              RSTn;
    logic              S_req;
    logic              Select;
    logic              S_ack;
    logic [DATA_W-1:0] M1_result;
    logic [DATA_W-1:0] M2_result;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_src;
    logic [2:0]        fifo_count;
`ifdef OUT_PARITY_EN
    logic              out_par;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    // Model: queue of {src, data}; ackNext = acknowledge shown after this edge;
    // waitRelease = requester has been acknowledged and must drop S_req before the next request.
    logic [DATA_W:0] mq[$];
    bit              ackNext;
    bit              waitRelease;

    fpu_result_writer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .CLK(CLK),
        .RSTn(RSTn),
        .S_req(S_req),
        .Select(Select),
        .S_ack(S_ack),
        .M1_result(M1_result),
        .M2_result(M2_result),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_src(out_src),
`ifdef OUT_PARITY_EN
        .out_par(out_par),
`endif
        .fifo_count(fifo_count)
    );

    always #5 CLK = ~CLK;

    // Advance one rising edge, update the model from the inputs it sampled, then settle.
    task automatic edgeStep();
        bit pushOk;
        bit popOk;
        @(posedge CLK);
        if (!RSTn) begin
            mq.delete();
            ackNext     = 1'b0;
            waitRelease = 1'b0;
        end else begin
            popOk  = out_ready && (mq.size() != 0);
            pushOk = !ackNext && !waitRelease && S_req && (mq.size() < DEPTH);
            if (popOk) mq.delete(0);
            if (pushOk) mq.push_back({Select, Select ? M2_result : M1_result});
            if (ackNext) begin
                ackNext     = 1'b0;
                waitRelease = 1'b1;
            end else if (waitRelease) begin
                if (!S_req) waitRelease = 1'b0;
            end else if (pushOk) begin
                ackNext = 1'b1;
            end
        end
        #1;
    endtask

    task automatic applyStimulus(input bit sel, input logic [DATA_W-1:0] d);
        Select    = sel;
        M1_result = sel ? $urandom : d;
        M2_result = sel ? d : $urandom;
        S_req     = 1'b1;
        edgeStep();
        S_req = 1'b0;
        edgeStep();
        edgeStep();
    endtask

    task automatic test_reset();
        RSTn = 1'b0; S_req = 1'b0; Select = 1'b0; out_ready = 1'b0;
        M1_result = '0; M2_result = '0;
        edgeStep();
        edgeStep();
        testsRun++; if (S_ack !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_sack got %b want 0", S_ack); end
        testsRun++; if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid got %b want 0", out_valid); end
        testsRun++; if (fifo_count !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_count got %0d want 0", fifo_count); end
        RSTn = 1'b1;
        edgeStep();
        testsRun++; if (S_ack !== 1'b0 || out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL post_reset got ack=%b valid=%b want 0/0", S_ack, out_valid); end
    endtask

    task automatic test_single_write();
        Select = 1'b0; M1_result = 32'h3F800000; M2_result = 32'hDEADBEEF; S_req = 1'b1;
        testsRun++; if (S_ack !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_preack got %b want 0", S_ack); end
        edgeStep();
        testsRun++; if (S_ack !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_ack got %b want 1", S_ack); end
        testsRun++; if (out_valid !== 1'b1 || fifo_count !== 3'd1) begin testsFailed++; $display("[TB] FAIL single_count got valid=%b count=%0d want 1/1", out_valid, fifo_count); end
        testsRun++; if (out_data !== 32'h3F800000 || out_src !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_data got %h/%b want 3f800000/0", out_data, out_src); end
        S_req = 1'b0;
        edgeStep();
        testsRun++; if (S_ack !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_ack_width got %b want 0", S_ack); end
        edgeStep();
        out_ready = 1'b1;
        edgeStep();
        out_ready = 1'b0;
        testsRun++; if (fifo_count !== 3'd0) begin testsFailed++; $display("[TB] FAIL single_drain got %0d want 0", fifo_count); end
    endtask

    task automatic test_source_mux();
        Select = 1'b1; M1_result = 32'h11111111; M2_result = 32'h40000000; S_req = 1'b1;
        edgeStep();
        testsRun++; if (out_data !== 32'h40000000 || out_src !== 1'b1) begin testsFailed++; $display("[TB] FAIL mux_data got %h/%b want 40000000/1", out_data, out_src); end
        S_req = 1'b0; Select = 1'b0;
        edgeStep();
        edgeStep();
        out_ready = 1'b1;
        edgeStep();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] expData [4];
        expData[0] = 32'd101; expData[1] = 32'd102; expData[2] = 32'd103; expData[3] = 32'd200;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'd100 + 32'(i));
        testsRun++; if (fifo_count !== 3'd4) begin testsFailed++; $display("[TB] FAIL bp_full got %0d want 4", fifo_count); end
        Select = 1'b0; M1_result = 32'd200; S_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            edgeStep();
            testsRun++; if (S_ack !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_noack cycle %0d got %b want 0", i, S_ack); end
        end
        testsRun++; if (fifo_count !== 3'd4) begin testsFailed++; $display("[TB] FAIL bp_hold got %0d want 4", fifo_count); end
        out_ready = 1'b1;
        edgeStep();
        out_ready = 1'b0;
        testsRun++; if (S_ack !== 1'b0 || fifo_count !== 3'd3) begin testsFailed++; $display("[TB] FAIL bp_pop got ack=%b count=%0d want 0/3", S_ack, fifo_count); end
        edgeStep();
        testsRun++; if (S_ack !== 1'b1 || fifo_count !== 3'd4) begin testsFailed++; $display("[TB] FAIL bp_late_ack got ack=%b count=%0d want 1/4", S_ack, fifo_count); end
        S_req = 1'b0;
        edgeStep();
        edgeStep();
        for (int i = 0; i < 4; i++) begin
            testsRun++; if (out_data !== expData[i]) begin testsFailed++; $display("[TB] FAIL bp_order %0d got %0d want %0d", i, out_data, expData[i]); end
            out_ready = 1'b1;
            edgeStep();
            out_ready = 1'b0;
        end
        testsRun++; if (fifo_count !== 3'd0) begin testsFailed++; $display("[TB] FAIL bp_drain got %0d want 0", fifo_count); end
    endtask

    task automatic test_push_pop();
        applyStimulus(1'b0, 32'hA);
        applyStimulus(1'b0, 32'hB);
        Select = 1'b0; M1_result = 32'hC; S_req = 1'b1; out_ready = 1'b1;
        edgeStep();
        S_req = 1'b0; out_ready = 1'b0;
        testsRun++; if (fifo_count !== 3'd2) begin testsFailed++; $display("[TB] FAIL pp_count got %0d want 2", fifo_count); end
        testsRun++; if (out_data !== 32'hB) begin testsFailed++; $display("[TB] FAIL pp_head1 got %h want b", out_data); end
        edgeStep();
        edgeStep();
        out_ready = 1'b1;
        edgeStep();
        out_ready = 1'b0;
        testsRun++; if (out_data !== 32'hC || fifo_count !== 3'd1) begin testsFailed++; $display("[TB] FAIL pp_head2 got %h count=%0d want c/1", out_data, fifo_count); end
        out_ready = 1'b1;
        edgeStep();
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        Select    = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            M1_result = 32'(i);
            S_req     = 1'b1;
            edgeStep();
            testsRun++; if (out_data !== 32'(i) || out_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL wrap_out %0d got %0d valid=%b want %0d", i, out_data, out_valid, i); end
            S_req = 1'b0;
            edgeStep();
            edgeStep();
        end
        out_ready = 1'b0;
        testsRun++; if (fifo_count !== 3'd0) begin testsFailed++; $display("[TB] FAIL wrap_end got %0d want 0", fifo_count); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        applyStimulus(1'b0, 32'd31);
        applyStimulus(1'b1, 32'd32);
        Select = 1'b0; M1_result = 32'd33; S_req = 1'b1;
        edgeStep();
        testsRun++; if (S_ack !== 1'b1 || fifo_count !== 3'd3) begin testsFailed++; $display("[TB] FAIL mid_setup got ack=%b count=%0d want 1/3", S_ack, fifo_count); end
        RSTn = 1'b0;
        edgeStep();
        testsRun++; if (S_ack !== 1'b0 || fifo_count !== 3'd0 || out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_reset got ack=%b count=%0d valid=%b want 0/0/0", S_ack, fifo_count, out_valid); end
        RSTn = 1'b1; S_req = 1'b0;
        edgeStep();
        testsRun++; if (S_ack !== 1'b0 || out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_after got ack=%b valid=%b want 0/0", S_ack, out_valid); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            RSTn      = ($urandom_range(0, 63) != 0);
            S_req     = ($urandom_range(0, 2) != 0);
            Select    = 1'($urandom);
            M1_result = $urandom;
            M2_result = $urandom;
            out_ready = ($urandom_range(0, 2) == 0);
            edgeStep();
            testsRun++; if (S_ack !== ackNext) begin testsFailed++; $display("[TB] FAIL rnd_ack c%0d got %b want %b", c, S_ack, ackNext); end
            testsRun++; if (fifo_count !== 3'(mq.size()) || out_valid !== (mq.size() != 0)) begin testsFailed++; $display("[TB] FAIL rnd_count c%0d got %0d/%b want %0d", c, fifo_count, out_valid, mq.size()); end
            if (mq.size() != 0) begin
                testsRun++; if ({out_src, out_data} !== mq[0]) begin testsFailed++; $display("[TB] FAIL rnd_head c%0d got %b/%h want %h", c, out_src, out_data, mq[0]); end
`ifdef OUT_PARITY_EN
                testsRun++; if (out_par !== ^mq[0]) begin testsFailed++; $display("[TB] FAIL rnd_par c%0d got %b want %b", c, out_par, ^mq[0]); end
`endif
            end
        end
        RSTn = 1'b1; S_req = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_source_mux();
        test_backpressure();
        test_push_pop();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/fpu_result_writer.md
FPU_RESULT_WRITER -- requirements
Module: fpu_result_writer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the result word width.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the result FIFO entry count; DEPTH SHALL be a power of 2 and at least 2.
REQ-003 The block SHALL have port CLK, input, 1 bit: clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RSTn, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port S_req, input, 1 bit: write request from the adder/multiplier interconnect.
REQ-006 The block SHALL have port Select, input, 1 bit: source of the request; 0 = M1 (adder), 1 = M2 (multiplier).
REQ-007 The block SHALL have port S_ack, output, 1 bit: one-cycle acknowledge to the interconnect.
REQ-008 The block SHALL have port M1_result, input, DATA_W bits: adder result.
REQ-009 The block SHALL have port M2_result, input, DATA_W bits: multiplier result.
REQ-010 The block SHALL have port out_valid, output, 1 bit: FIFO head valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer accepts the head.
REQ-012 The block SHALL have port out_data, output, DATA_W bits: FIFO head data.
REQ-013 The block SHALL have port out_src, output, 1 bit: Select value stored with the head entry.
REQ-014 The block SHALL have port fifo_count, output, log2(DEPTH)+1 bits: number of occupied entries.

Function
REQ-015 The FSM SHALL have three states: WB_IDLE, WB_ACK and WB_DROP.
REQ-016 In WB_IDLE with S_req=1 and fifo_count<DEPTH at a rising edge, the block SHALL push {Select, Select ? M2_result : M1_result} and move to WB_ACK.
REQ-017 In WB_IDLE with S_req=1 and fifo_count==DEPTH (full), the block SHALL stay in WB_IDLE and push nothing; S_ack stays 0 until space exists (backpressure).
REQ-018 In WB_ACK, S_ack SHALL be 1 for exactly that cycle, with no other push; the FSM SHALL then go to WB_DROP.
REQ-019 In WB_DROP, S_ack SHALL be 0 and the FSM SHALL return to WB_IDLE on the first edge that samples S_req=0.
REQ-020 S_ack SHALL be driven only from the FSM state (registered), never combinationally from S_req.
REQ-021 Acknowledge latency SHALL be 1 cycle: a request captured at edge N gives S_ack=1 during cycle N..N+1.
REQ-022 The full check SHALL use the registered fifo_count; a pop in the same cycle SHALL NOT unblock a push while full.
REQ-023 A pop SHALL occur on an edge where out_valid=1 and out_ready=1.
REQ-024 out_valid SHALL equal (fifo_count!=0); out_data and out_src SHALL present the oldest entry.
REQ-025 When push and pop occur on the same edge, fifo_count SHALL be unchanged and the FIFO order preserved.
REQ-026 out_ready=1 while the FIFO is empty SHALL have no effect.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.
REQ-028 If S_req falls while in WB_ACK, the captured entry SHALL remain in the FIFO, and S_ack SHALL still pulse.

Reset
REQ-029 On an edge with RSTn=0, the FSM SHALL go to WB_IDLE and both pointers and fifo_count SHALL clear to 0.
REQ-030 While RSTn=0 and on the cycle after reset, S_ack SHALL be 0 and out_valid SHALL be 0.
REQ-031 FIFO storage contents SHALL NOT require reset; out_data is don't-care while out_valid=0.
REQ-032 Reset asserted mid-handshake SHALL discard all entries and any pending S_ack.

Configuration
REQ-033 With macro OUT_PARITY_EN defined, each entry SHALL store an even-parity bit over {Select, data}, computed at push.
REQ-034 With OUT_PARITY_EN defined, that bit SHALL be presented on an extra output out_par, 1 bit.
REQ-035 Without OUT_PARITY_EN, the out_par port and the parity storage SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-036 Bench SHALL cover single write: reset, then S_req=1, Select=0, M1_result=32'h3F800000 -> S_ack pulses 1 cycle later; out_valid=1, out_data=32'h3F800000, out_src=0, fifo_count=1.
REQ-037 Bench SHALL cover source mux: Select=1, M1_result=32'h11111111, M2_result=32'h40000000 -> stored out_data=32'h40000000, out_src=1.
REQ-038 Bench SHALL cover full backpressure: 4 writes with out_ready=0, then a 5th S_req held 3 cycles -> no S_ack and fifo_count=4; assert out_ready 1 cycle -> S_ack pulses 2 cycles later.
REQ-039 Bench SHALL cover simultaneous push/pop: fifo_count=2 with out_ready=1 and a push on the same edge -> fifo_count stays 2, FIFO order preserved.
REQ-040 Bench SHALL cover wrap-around: 10 writes of values 1..10 with out_ready=1 -> outputs 1..10 in order, fifo_count=0 at end.
REQ-041 Bench SHALL cover reset mid-operation: RSTn=0 in WB_ACK with fifo_count=3 -> next cycle S_ack=0, fifo_count=0, out_valid=0.
